// File: rtl/alu.sv
// Registered 32-bit integer ALU for the execute stage: one clock from operands to result/zero.
// Optional flag outputs (negative, carry, overflow) are built only when ALU_FLAGS_EN is defined.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             negative,
  output logic             carry,
  output logic             overflow
`endif
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic [WIDTH-1:0] add_r, sub_r;
  logic [SHW-1:0]   shamt;

  // Only the low log2(WIDTH) bits of b form the shift amount.
  assign shamt = b[SHW-1:0];

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_x, sub_x;
  logic           neg_d, neg_q;
  logic           carry_d, carry_q;
  logic           ovf_d, ovf_q;

  assign add_x = {1'b0, a} + {1'b0, b};
  assign sub_x = {1'b0, a} - {1'b0, b};
  assign add_r = add_x[WIDTH-1:0];
  assign sub_r = sub_x[WIDTH-1:0];
`else
  assign add_r = a + b;
  assign sub_r = a - b;
`endif

  always_comb begin
    result_d = '0;
    unique case (alu_control)
      OP_ADD:  result_d = add_r;
      OP_SUB:  result_d = sub_r;
      OP_SRA:  result_d = $unsigned($signed(a) >>> shamt);
      OP_SLL:  result_d = a << shamt;
      OP_SRL:  result_d = a >> shamt;
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result_d = '0;
    endcase
    // Derived from result_d so zero never lags the result it describes.
    zero_d = (result_d == '0);
  end

`ifdef ALU_FLAGS_EN
  always_comb begin
    neg_d   = result_d[WIDTH-1];
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    if (alu_control == OP_ADD) begin
      carry_d = add_x[WIDTH];
      ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
    end else if (alu_control == OP_SUB) begin
      // Carry on subtract is "no borrow", i.e. a >= b unsigned.
      carry_d = ~sub_x[WIDTH];
      ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign negative = neg_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
`endif

  // No handshake: operands are captured on every rising edge while rst is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic model of the eight operations.
module tb_alu;

  localparam int WIDTH = 32;
  localparam int W     = WIDTH + 4;   // {overflow, carry, negative, zero, result}

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       ctl;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef ALU_FLAGS_EN
  logic             negative, carry, overflow;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  logic [W-1:0] reset_vec;

  alu #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .alu_control (ctl),
    .result      (result),
    .zero        (zero)
`ifdef ALU_FLAGS_EN
    ,
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [W-1:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] op);
    int unsigned       sh;
    longint            sx, sy, s, rs;
    longint unsigned   ux, uy;
    logic [31:0]       r;
    logic              c, v;
    sh = y % WIDTH;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    s  = 0;
    case (op)
      3'd0: begin
        r = 32'(ux + uy);
        c = (ux + uy) > 64'h0000_0000_FFFF_FFFF;
        s = sx + sy;
        rs = $signed(r);
        v = (s != rs);
      end
      3'd1: begin
        r = 32'(ux - uy);
        c = (ux >= uy);
        s = sx - sy;
        rs = $signed(r);
        v = (s != rs);
      end
      3'd2: r = 32'(sx >>> sh);
      3'd3: r = 32'(ux * (64'd1 << sh));
      3'd4: r = 32'(ux / (64'd1 << sh));
      3'd5: r = x & y;
      3'd6: r = x | y;
      default: r = (sx < sy) ? 32'd1 : 32'd0;
    endcase
    model = {v, c, r[31], (r == 32'd0), r};
  endfunction

  // ---------------- checks ----------------
  function automatic logic [W-1:0] actual_vec();
`ifdef ALU_FLAGS_EN
    actual_vec = {overflow, carry, negative, zero, result};
`else
    actual_vec = {3'b000, zero, result};
`endif
  endfunction

  task automatic check_vec(input string nm, input logic [W-1:0] exp);
    logic [W-1:0] mask, act;
`ifdef ALU_FLAGS_EN
    mask = '1;
`else
    mask = {3'b000, 1'b1, {WIDTH{1'b1}}};
`endif
    act = actual_vec();
    total++;
    if ((act & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %s: got {ovf,c,n,z,res}=%h expected %h (t=%0t)", nm, act & mask, exp & mask, $time);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] er, input logic ez);
    total++;
    if (result !== er || zero !== ez) begin
      bad++;
      $display("FAIL %s: got result=%h zero=%b expected result=%h zero=%b", nm, result, zero, er, ez);
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic lit_flags(input string nm, input logic en, input logic ec, input logic eo);
    total++;
    if (negative !== en || carry !== ec || overflow !== eo) begin
      bad++;
      $display("FAIL %s: got n=%b c=%b v=%b expected n=%b c=%b v=%b",
               nm, negative, carry, overflow, en, ec, eo);
    end
  endtask
`endif

  // Scoreboard: expectation pushed at the capturing edge, compared shortly after.
  always @(posedge clk) begin
    if (!rst) exp_q.push_back(model(a, b, ctl));
    #2;
    if (rst) begin
      check_vec("reset_hold", reset_vec);
      last_exp = reset_vec;
    end else if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check_vec("model", last_exp);
    end
  end

  always @(posedge rst) exp_q.delete();

  // ---------------- drivers ----------------
  task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    @(negedge clk);
    a   = x;
    b   = y;
    ctl = op;
    #1;
    // Output must still show the previous operation until the next edge.
    if (!rst) check_vec("hold_until_edge", last_exp);
    @(posedge clk);
    #3;
  endtask

  task automatic rst_pulse(input string nm);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 lit(nm, 32'd0, 1'b1);
`ifdef ALU_FLAGS_EN
    lit_flags({nm, "_flags"}, 1'b0, 1'b0, 1'b0);
`endif
    #1 rst = 1'b0;
    last_exp = reset_vec;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_vec = {3'b000, 1'b1, {WIDTH{1'b0}}};
    last_exp  = reset_vec;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    ctl = 3'd0;
    #1 lit("reset_state", 32'd0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    apply(32'd9, 32'd9, 3'b000);
    lit("add_pre", 32'd18, 1'b0);
    rst_pulse("rst_async");
    apply(32'd2, 32'd3, 3'b000);
    lit("add_2_3", 32'd5, 1'b0);

    apply(32'd5, 32'd12, 3'b001);
    lit("sub_neg", 32'hFFFF_FFF9, 1'b0);
    apply(32'd7, 32'd7, 3'b001);
    lit("sub_zero", 32'd0, 1'b1);

    apply(32'h0000_FFFF, 32'h000F_FFFF, 3'b110);
    lit("or", 32'h000F_FFFF, 1'b0);
    apply(32'h0000_FFFF, 32'h000F_FFFF, 3'b101);
    lit("and", 32'h0000_FFFF, 1'b0);

    apply(32'hFFFF_F000, 32'd4, 3'b010);
    lit("sra4", 32'hFFFF_FF00, 1'b0);
    apply(32'hFFFF_F000, 32'd4, 3'b100);
    lit("srl4", 32'h0FFF_FF00, 1'b0);
    apply(32'hFFFF_F000, 32'd4, 3'b011);
    lit("sll4", 32'hFFFF_0000, 1'b0);
    apply(32'hFFFF_F000, 32'h24, 3'b010);
    lit("sra_masked_amt", 32'hFFFF_FF00, 1'b0);
    apply(32'hFFFF_F000, 32'h24, 3'b011);
    lit("sll_masked_amt", 32'hFFFF_0000, 1'b0);
    apply(32'hFFFF_F000, 32'd0, 3'b100);
    lit("srl_by0", 32'hFFFF_F000, 1'b0);
    apply(32'h8000_0000, 32'd31, 3'b010);
    lit("sra31", 32'hFFFF_FFFF, 1'b0);
    apply(32'h8000_0000, 32'd31, 3'b100);
    lit("srl31", 32'h0000_0001, 1'b0);

    apply(32'hFFFF_FFFF, 32'd1, 3'b111);
    lit("slt_true", 32'd1, 1'b0);
    apply(32'd1, 32'hFFFF_FFFF, 3'b111);
    lit("slt_false", 32'd0, 1'b1);
    apply(32'hFFFF_FFFF, 32'd1, 3'b111);
    rst_pulse("rst_mid_slt");

    apply(32'h7FFF_FFFF, 32'd1, 3'b000);
    lit("add_ovf", 32'h8000_0000, 1'b0);
`ifdef ALU_FLAGS_EN
    lit_flags("add_ovf_flags", 1'b1, 1'b0, 1'b1);
`endif
    apply(32'hFFFF_FFFF, 32'd1, 3'b000);
    lit("add_carry", 32'd0, 1'b1);
`ifdef ALU_FLAGS_EN
    lit_flags("add_carry_flags", 1'b0, 1'b1, 1'b0);
    apply(32'h8000_0000, 32'd1, 3'b001);
    lit_flags("sub_ovf_flags", 1'b0, 1'b1, 1'b1);
    apply(32'd3, 32'd4, 3'b001);
    lit_flags("sub_borrow_flags", 1'b1, 1'b0, 1'b0);
`endif

    // Back-to-back stream of changing operations, with reset held across an edge midway.
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #3;
        @(negedge clk);
        rst = 1'b0;
        last_exp = reset_vec;
      end
      apply($urandom, (i % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom,
            3'($urandom_range(0, 7)));
    end

    apply(32'd0, 32'd0, 3'b110);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
